oai_aoi_pipe: RTL and testbench



---
 rtl/oai_aoi_pipe.sv | 113 +++++++++++
 tb/tb_oai_aoi_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oai_aoi_pipe.sv
// oai_aoi_pipe: registered, flow-controlled complex gate (OAI/AOI/OA/AO).
// Stage 1 holds the per-group reductions and stage 2 holds the combined
// result. A valid/ready handshake at full throughput links the two stages.
module oai_aoi_pipe #(
  parameter int WIDTH  = 8,
  parameter int GROUPS = 2,
  parameter int TERMS  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_mode,
  input  logic [GROUPS*TERMS*WIDTH-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [1:0]                      out_mode,
  output logic                            busy
);

  typedef enum logic [1:0] {
    MODE_OAI = 2'd0,
    MODE_AOI = 2'd1,
    MODE_OA  = 2'd2,
    MODE_AO  = 2'd3
  } mode_e;

  mode_e                    in_m;
  mode_e                    s1_mode;
  logic                     s1_valid;
  logic [GROUPS*WIDTH-1:0]  s1_grp;
  logic [GROUPS*WIDTH-1:0]  grp_next;
  logic [WIDTH-1:0]         res_next;
  logic                     grp_and;
  logic                     comb_or;
  logic                     invert;
  logic                     s2_free;
  logic                     s1_adv;
  logic                     in_fire;

  assign in_m     = mode_e'(in_mode);
  assign s2_free  = ~out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = ~s1_valid | s1_adv;
  assign in_fire  = in_valid & in_ready;
  assign busy     = s1_valid | out_valid;

  // First level: per lane, reduce each group's terms (AND for AOI/AO, else OR)
  always_comb begin
    logic [TERMS-1:0] terms;
    grp_next = '0;
    terms    = '0;
    grp_and  = (in_m == MODE_AOI) || (in_m == MODE_AO);
    for (int unsigned g = 0; g < GROUPS; g++) begin
      for (int unsigned w = 0; w < WIDTH; w++) begin
        for (int unsigned t = 0; t < TERMS; t++) begin
          terms[t] = in_data[(g*TERMS + t)*WIDTH + w];
        end
        grp_next[g*WIDTH + w] = grp_and ? (&terms) : (|terms);
      end
    end
  end

  // Second level: combine group results per lane, then optionally invert
  always_comb begin
    logic [GROUPS-1:0] gv;
    logic              comb;
    res_next = '0;
    gv       = '0;
    comb     = 1'b0;
    comb_or  = (s1_mode == MODE_AOI) || (s1_mode == MODE_AO);
    invert   = (s1_mode == MODE_OAI) || (s1_mode == MODE_AOI);
    for (int unsigned w = 0; w < WIDTH; w++) begin
      for (int unsigned g = 0; g < GROUPS; g++) begin
        gv[g] = s1_grp[g*WIDTH + w];
      end
      comb        = comb_or ? (|gv) : (&gv);
      res_next[w] = invert ? ~comb : comb;
    end
  end

  // Stage 1 register: loads on input handshake, empties when it advances alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_OAI;
      s1_grp   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_m;
      s1_grp   <= grp_next;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: loads when stage 1 advances, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= res_next;
      out_mode  <= s1_mode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oai_aoi_pipe.sv
// Bench for oai_aoi_pipe: default instance for directed scenarios and a
// WIDTH=5/GROUPS=3/TERMS=4 instance for randomized traffic.
module tb_oai_aoi_pipe;

  int total = 0;
  int bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [1:0]  in_mode = '0, out_mode;
  logic [31:0] in_data = '0;
  logic [7:0]  out_data;

  // generalised instance
  logic        g_in_valid = 1'b0, g_in_ready, g_out_valid, g_out_ready = 1'b0, g_busy;
  logic [1:0]  g_in_mode = '0, g_out_mode;
  logic [59:0] g_in_data = '0;
  logic [4:0]  g_out_data;

  oai_aoi_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode), .busy(busy)
  );

  oai_aoi_pipe #(.WIDTH(5), .GROUPS(3), .TERMS(4)) dut_g (
    .clk(clk), .rst_n(rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_mode(g_in_mode), .in_data(g_in_data), .out_valid(g_out_valid),
    .out_ready(g_out_ready), .out_data(g_out_data), .out_mode(g_out_mode), .busy(g_busy)
  );

  // Reference: count set terms per group, then count qualifying groups.
  function automatic logic [7:0] ref_model(input int w, input int ng, input int nt,
                                           input logic [1:0] mode, input logic [63:0] d);
    logic [7:0] r;
    int any_cnt, all_cnt, ones;
    r = '0;
    for (int lane = 0; lane < w; lane++) begin
      any_cnt = 0;
      all_cnt = 0;
      for (int gi = 0; gi < ng; gi++) begin
        ones = 0;
        for (int ti = 0; ti < nt; ti++) ones += int'(d[(gi*nt + ti)*w + lane]);
        if (ones > 0)  any_cnt++;
        if (ones == nt) all_cnt++;
      end
      case (mode)
        2'd0:    r[lane] = !(any_cnt == ng);
        2'd1:    r[lane] = !(all_cnt > 0);
        2'd2:    r[lane] = (any_cnt == ng);
        default: r[lane] = (all_cnt > 0);
      endcase
    end
    return r;
  endfunction

  logic [9:0] exp_q[$];
  logic [6:0] gexp_q[$];
  logic       o_valid, o_ready, o_busy;
  logic [7:0] o_data;
  logic [1:0] o_mode;
  logic       go_valid, go_ready;
  logic [4:0] go_data;
  logic [1:0] go_mode;

  task automatic step(input logic v, input logic [1:0] m, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_mode   = m;
    in_data   = v ? d : 'x;
    out_ready = rdy;
    #1;
    o_valid = out_valid;
    o_ready = in_ready;
    o_busy  = busy;
    o_data  = out_data;
    o_mode  = out_mode;
    if (v && in_ready) exp_q.push_back({m, ref_model(8, 2, 2, m, {32'b0, d})});
  endtask

  task automatic step_g(input logic v, input logic [1:0] m, input logic [59:0] d, input logic rdy);
    logic [7:0] r;
    @(negedge clk);
    g_in_valid  = v;
    g_in_mode   = m;
    g_in_data   = v ? d : 'x;
    g_out_ready = rdy;
    #1;
    go_valid = g_out_valid;
    go_ready = g_in_ready;
    go_data  = g_out_data;
    go_mode  = g_out_mode;
    r = ref_model(5, 3, 4, m, {4'b0, d});
    if (v && g_in_ready) gexp_q.push_back({m, r[4:0]});
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, in_ready, out_data, out_mode} !== {1'b0, 1'b0, 1'b1, 8'h00, 2'd0}) begin
      bad++;
      $display("FAIL reset_init got v=%b busy=%b rdy=%b d=%h m=%0d want 0 0 1 00 0",
               out_valid, busy, in_ready, out_data, out_mode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // fill both stages, then reset asynchronously mid-cycle
    step(1'b1, 2'd3, $urandom, 1'b0);
    step(1'b1, 2'd2, $urandom, 1'b0);
    step(1'b0, 2'd0, '0, 1'b0);
    total++;
    if ({o_valid, o_ready, o_busy} !== 3'b101) begin
      bad++;
      $display("FAIL full_before_reset got v=%b rdy=%b busy=%b want 1 0 1", o_valid, o_ready, o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, in_ready, out_data, out_mode} !== {1'b0, 1'b0, 1'b1, 8'h00, 2'd0}) begin
      bad++;
      $display("FAIL reset_midstream got v=%b busy=%b rdy=%b d=%h m=%0d want 0 0 1 00 0",
               out_valid, busy, in_ready, out_data, out_mode);
    end
    exp_q.delete();
    gexp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'd0, '0, 1'b1);
      total++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL stale_after_reset cyc=%0d got v=%b busy=%b want 0 0", k, o_valid, o_busy);
      end
    end
  endtask

  task automatic test_oai();
    logic [31:0] dv[2];
    logic [7:0]  ev[2];
    dv[0] = 32'h0100F00F; ev[0] = 8'hFE;
    dv[1] = 32'h0000F00F; ev[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'd0, dv[i], 1'b1);
      step(1'b0, 2'd0, '0, 1'b1);
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("FAIL oai_early case=%0d got v=%b want 0", i, o_valid);
      end
      step(1'b0, 2'd0, '0, 1'b1);
      total++;
      if ({o_valid, o_mode, o_data} !== {1'b1, 2'd0, ev[i]}) begin
        bad++;
        $display("FAIL oai_result case=%0d got v=%b m=%0d d=%h want 1 0 %h", i, o_valid, o_mode, o_data, ev[i]);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_modes();
    logic [7:0] tbl[4];
    tbl[0] = 8'h11; tbl[1] = 8'h77; tbl[2] = 8'hEE; tbl[3] = 8'h88;
    for (int k = 0; k < 8; k++) begin
      step(k < 4, 2'(k), 32'h0FF0AACC, 1'b1);
      total++;
      if (k >= 2 && k <= 5) begin
        if ({o_valid, o_mode, o_data} !== {1'b1, 2'(k-2), tbl[k-2]}) begin
          bad++;
          $display("FAIL modes_b2b cyc=%0d got v=%b m=%0d d=%h want 1 %0d %h",
                   k, o_valid, o_mode, o_data, k-2, tbl[k-2]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (o_valid !== 1'b0) begin
        bad++;
        $display("FAIL modes_gap cyc=%0d got v=%b want 0", k, o_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    int sent = 0, got = 0, cyc = 0;
    logic saw_full = 1'b0, prev_stall = 1'b0, v, rdy;
    logic [9:0] prev_out = '0, e;
    logic [31:0] d = $urandom;
    logic [1:0]  m = 2'($urandom);
    while (got < 6 && cyc < 60) begin
      rdy = (cyc % 3 == 0);
      v   = (sent < 6);
      step(v, m, d, rdy);
      if (v && o_ready) begin
        sent++;
        d = $urandom;
        m = 2'($urandom);
      end
      if (v && !o_ready) saw_full = 1'b1;
      if (prev_stall) begin
        total++;
        if ({o_mode, o_data} !== prev_out) begin
          bad++;
          $display("FAIL bp_hold cyc=%0d got %h want %h", cyc, {o_mode, o_data}, prev_out);
        end
      end
      if (o_valid && rdy) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra got %h want none", {o_mode, o_data});
        end else begin
          e = exp_q.pop_front();
          if ({o_mode, o_data} !== e) begin
            bad++;
            $display("FAIL bp_data got %h want %h", {o_mode, o_data}, e);
          end
        end
      end
      prev_stall = o_valid && !rdy;
      prev_out   = {o_mode, o_data};
      cyc++;
    end
    total++;
    if (got != 6 || !saw_full || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_summary got=%0d full=%b left=%0d want 6 1 0", got, saw_full, exp_q.size());
    end
  endtask

  task automatic test_back_to_back_full();
    logic [31:0] d[3];
    logic [1:0]  m[3];
    logic [7:0]  r;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      m[i] = 2'($urandom);
    end
    step(1'b1, m[0], d[0], 1'b0);
    step(1'b1, m[1], d[1], 1'b0);
    step(1'b1, m[2], d[2], 1'b1);
    r = ref_model(8, 2, 2, m[0], {32'b0, d[0]});
    total++;
    if ({o_ready, o_valid, o_mode, o_data} !== {1'b1, 1'b1, m[0], r}) begin
      bad++;
      $display("FAIL pass_through got rdy=%b v=%b m=%0d d=%h want 1 1 %0d %h",
               o_ready, o_valid, o_mode, o_data, m[0], r);
    end
    for (int i = 1; i < 3; i++) begin
      step(1'b0, 2'd0, '0, 1'b1);
      r = ref_model(8, 2, 2, m[i], {32'b0, d[i]});
      total++;
      if ({o_valid, o_busy, o_mode, o_data} !== {1'b1, 1'b1, m[i], r}) begin
        bad++;
        $display("FAIL pass_next idx=%0d got v=%b busy=%b m=%0d d=%h want 1 1 %0d %h",
                 i, o_valid, o_busy, o_mode, o_data, m[i], r);
      end
    end
    step(1'b0, 2'd0, '0, 1'b1);
    total++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL drain got v=%b busy=%b want 0 0", o_valid, o_busy);
    end
    exp_q.delete();
  endtask

  task automatic test_random_generalised();
    int sent = 0, got = 0, cyc = 0;
    logic v, rdy;
    logic [1:0]  m;
    logic [59:0] d;
    logic [6:0]  e;
    while ((sent < 1000 || gexp_q.size() > 0) && cyc < 20000) begin
      v   = (sent < 1000) && ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      m   = 2'($urandom);
      d   = {$urandom, $urandom};
      step_g(v, m, d, rdy);
      if (v && go_ready) sent++;
      if (go_valid && rdy) begin
        got++;
        total++;
        if (gexp_q.size() == 0) begin
          bad++;
          $display("FAIL gen_extra got %h want none", {go_mode, go_data});
        end else begin
          e = gexp_q.pop_front();
          if ({go_mode, go_data} !== e) begin
            bad++;
            $display("FAIL gen_data n=%0d got m=%0d d=%h want m=%0d d=%h",
                     got, go_mode, go_data, e[6:5], e[4:0]);
          end
        end
      end
      cyc++;
    end
    total++;
    if (sent != 1000 || got != 1000 || gexp_q.size() != 0) begin
      bad++;
      $display("FAIL gen_summary sent=%0d got=%0d left=%0d want 1000 1000 0", sent, got, gexp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_oai();
    test_modes();
    test_back_pressure();
    test_back_to_back_full();
    test_random_generalised();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
